irq_modport: RTL and testbench
==============================

IRQ_MODPORT -- requirements
Module: irq_modport

Interface
REQ-001 Parameter: SYNC_STAGES, default 1, number of input register stages per IRQ line (legal 1..3).
REQ-002 Parameter: MIE_RST, default 32'h0, reset value of the mie register.
REQ-003 ms_riscv32_mp_clk_in  in  1  sole clock, all state rising-edge.
REQ-004 ms_riscv32_mp_rst_in  in  1  reset, asynchronous, active-low.
REQ-005 ms_riscv32_mp_eirq_in  in  1  machine external interrupt request, level.
REQ-006 ms_riscv32_mp_tirq_in  in  1  machine timer interrupt request, level.
REQ-007 ms_riscv32_mp_sirq_in  in  1  machine software interrupt request, level.
REQ-008 mstatus_mie_in  in  1  global machine interrupt enable from CSR file.
REQ-009 csr_wr_en_in  in  1  CSR write strobe.
REQ-010 csr_addr_in  in  12  CSR address for read and write.
REQ-011 csr_wr_data_in  in  32  CSR write data.
REQ-012 csr_rd_data_out  out  32  CSR read data, combinational.
REQ-013 mip_out  out  32  current mip value.
REQ-014 mie_out  out  32  current mie value.
REQ-015 irq_req_out  out  1  interrupt request to core trap logic.
REQ-016 irq_cause_out  out  4  mcause exception code of the selected interrupt.

Function
REQ-017 Each IRQ input SHALL pass through SYNC_STAGES flops; mip bit follows the last stage.
REQ-018 mip[11]=MEIP (eirq), mip[7]=MTIP (tirq), mip[3]=MSIP (sirq); all other mip bits read 0.
REQ-019 mip SHALL be read-only; CSR writes to 12'h344 are ignored.
REQ-020 CSR write with csr_addr_in=12'h304 SHALL update mie[11], mie[7], mie[3] at the next rising edge; other mie bits stay 0.
REQ-021 csr_rd_data_out SHALL return mie at 12'h304, mip at 12'h344, 32'h0 at any other address.
REQ-022 pending = mip & mie; irq_req_out = mstatus_mie_in & (pending != 0), combinational from registered state.
REQ-023 Latency: IRQ input sampled high at edge N produces mip bit and irq_req_out high after edge N+SYNC_STAGES-1.
REQ-024 Priority when several pending: MEI (cause 11) > MSI (cause 3) > MTI (cause 7).
REQ-025 irq_cause_out SHALL be 4'd0 when irq_req_out is low.
REQ-026 Sources are level-sensitive; the request persists until the input deasserts or is masked by mie/mstatus_mie_in, with no internal acknowledge or latching.
REQ-027 A mie write in the same cycle an input changes SHALL apply both at the same edge; new mask applies to new mip.
REQ-028 Deassertion of mstatus_mie_in SHALL drop irq_req_out in the same cycle without altering mip or mie.

Reset
REQ-029 On ms_riscv32_mp_rst_in low, all sync flops and mip SHALL clear to 0 immediately, mie SHALL load MIE_RST (masked to bits 11/7/3).
REQ-030 Reset asserted mid-request SHALL drop irq_req_out and irq_cause_out to 0 asynchronously.
REQ-031 After reset release, the first rising edge samples inputs normally.

Structure
REQ-032 Package msrv32_irq_pkg SHALL hold CSR addresses (MIE 12'h304, MIP 12'h344), bit positions (11, 7, 3) and cause codes.
REQ-033 One sub-module irq_sync (parameterised N-stage flop chain with async active-low reset) SHALL be instantiated per IRQ line.

Verification
REQ-034 Reset, then read 12'h304 and 12'h344 -> both 32'h0, irq_req_out 0, irq_cause_out 0.
REQ-035 Write mie=32'h888, mstatus_mie_in=1, tirq=1 -> mip=32'h80, irq_req_out=1, irq_cause_out=7 after SYNC_STAGES edges.
REQ-036 eirq, tirq, sirq all 1, mie=32'h888 -> irq_cause_out=11; drop eirq -> cause 3; drop sirq -> cause 7.
REQ-037 sirq=1, mie=32'h008, mstatus_mie_in=0 -> mip=32'h8, irq_req_out=0; set mstatus_mie_in=1 -> irq_req_out=1 same cycle.
REQ-038 Write 32'hFFFF_FFFF to 12'h304 and 12'h344 -> mie reads 32'h888, mip unchanged.
REQ-039 Assert reset while eirq=1 request active -> irq_req_out 0 immediately; release with eirq=1 -> mip[11]=1 after SYNC_STAGES edges, irq_req_out stays 0 (mie=0).

Source files
------------

// File: rtl/irq_modport_pkg.sv
// Shared constants for the machine-mode interrupt block: CSR addresses,
// mip/mie bit positions, mcause codes and the fixed-priority selector.
package msrv32_irq_pkg;

    localparam logic [11:0] CSR_MIE_ADDR = 12'h304;
    localparam logic [11:0] CSR_MIP_ADDR = 12'h344;

    localparam int MEI_BIT = 11;
    localparam int MTI_BIT = 7;
    localparam int MSI_BIT = 3;

    // Only these mie/mip bits are implemented; every other bit reads 0.
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

    localparam logic [3:0] CAUSE_NONE = 4'd0;
    localparam logic [3:0] CAUSE_MEI  = 4'd11;
    localparam logic [3:0] CAUSE_MTI  = 4'd7;
    localparam logic [3:0] CAUSE_MSI  = 4'd3;

    // Which source wins arbitration; also handy as a debug view.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MEI  = 2'd1,
        SRC_MSI  = 2'd2,
        SRC_MTI  = 2'd3
    } irq_src_e;

    // Fixed priority: external, then software, then timer.
    function automatic irq_src_e irq_select(input logic [31:0] pending);
        irq_src_e src;
        src = SRC_NONE;
        if (pending[MEI_BIT])      src = SRC_MEI;
        else if (pending[MSI_BIT]) src = SRC_MSI;
        else if (pending[MTI_BIT]) src = SRC_MTI;
        return src;
    endfunction

    function automatic logic [3:0] irq_cause(input irq_src_e src);
        logic [3:0] cause;
        case (src)
            SRC_MEI: cause = CAUSE_MEI;
            SRC_MSI: cause = CAUSE_MSI;
            SRC_MTI: cause = CAUSE_MTI;
            default: cause = CAUSE_NONE;
        endcase
        return cause;
    endfunction

endpackage

// File: rtl/irq_modport_if.sv
// CSR access bus between the CSR file (master) and the interrupt block (slave).
//
// Bus semantics: there is no valid/ready pair. csr_wr_en_in is a one-cycle
// write strobe; the write is taken at the rising edge where it is high and
// always completes (the slave never stalls). csr_rd_data_out is a purely
// combinational function of csr_addr_in and registered state, valid in the
// same cycle the address is presented.
interface irq_modport_if;
    logic        csr_wr_en_in;
    logic [11:0] csr_addr_in;
    logic [31:0] csr_wr_data_in;
    logic [31:0] csr_rd_data_out;

    modport master (
        output csr_wr_en_in,
        output csr_addr_in,
        output csr_wr_data_in,
        input  csr_rd_data_out
    );

    modport slave (
        input  csr_wr_en_in,
        input  csr_addr_in,
        input  csr_wr_data_in,
        output csr_rd_data_out
    );
endinterface

// File: rtl/irq_modport_sync.sv
// N-stage flop chain for one asynchronous interrupt line. The output is the
// last stage itself, so a level sampled at edge K appears after edge K+N-1.
module irq_sync #(
    parameter int N = 1  // legal 1..3
) (
    input  logic ms_riscv32_mp_clk_in,
    input  logic ms_riscv32_mp_rst_in,
    input  logic irq_in,
    output logic irq_sync_out
);

    logic [N:0] chain;

    assign chain[0] = irq_in;

    // Shift the level down the chain; reset clears every stage at once.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) chain[N:1] <= '0;
        else                       chain[N:1] <= chain[N-1:0];
    end

    assign irq_sync_out = chain[N];

endmodule

// File: rtl/irq_modport.sv
// Machine-mode interrupt controller: synchronises the three level-sensitive
// interrupt lines into mip, holds the mie mask, exposes both over the CSR bus
// and raises a prioritised request toward the trap logic.
module irq_modport
    import msrv32_irq_pkg::*;
#(
    parameter int          SYNC_STAGES = 1,      // legal 1..3
    parameter logic [31:0] MIE_RST     = 32'h0
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_in,
    input  logic                ms_riscv32_mp_eirq_in,
    input  logic                ms_riscv32_mp_tirq_in,
    input  logic                ms_riscv32_mp_sirq_in,
    input  logic                mstatus_mie_in,
    irq_modport_if.slave        csr_if,
    output logic [31:0]         mip_out,
    output logic [31:0]         mie_out,
    output logic                irq_req_out,
    output logic [3:0]          irq_cause_out
);

    logic        meip_sync;
    logic        mtip_sync;
    logic        msip_sync;
    logic [31:0] mie_q;
    logic [31:0] mip;
    logic [31:0] pending;
    irq_src_e    winner;

    irq_sync #(.N(SYNC_STAGES)) u_sync_eirq (
        .ms_riscv32_mp_clk_in (ms_riscv32_mp_clk_in),
        .ms_riscv32_mp_rst_in (ms_riscv32_mp_rst_in),
        .irq_in               (ms_riscv32_mp_eirq_in),
        .irq_sync_out         (meip_sync)
    );

    irq_sync #(.N(SYNC_STAGES)) u_sync_tirq (
        .ms_riscv32_mp_clk_in (ms_riscv32_mp_clk_in),
        .ms_riscv32_mp_rst_in (ms_riscv32_mp_rst_in),
        .irq_in               (ms_riscv32_mp_tirq_in),
        .irq_sync_out         (mtip_sync)
    );

    irq_sync #(.N(SYNC_STAGES)) u_sync_sirq (
        .ms_riscv32_mp_clk_in (ms_riscv32_mp_clk_in),
        .ms_riscv32_mp_rst_in (ms_riscv32_mp_rst_in),
        .irq_in               (ms_riscv32_mp_sirq_in),
        .irq_sync_out         (msip_sync)
    );

    // mip is read-only: it is the last sync stage of each line, nothing more.
    always_comb begin
        mip          = '0;
        mip[MEI_BIT] = meip_sync;
        mip[MTI_BIT] = mtip_sync;
        mip[MSI_BIT] = msip_sync;
    end

    // mie register: only the three implemented enable bits are writable.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in)
            mie_q <= MIE_RST & IRQ_MASK;
        else if (csr_if.csr_wr_en_in && (csr_if.csr_addr_in == CSR_MIE_ADDR))
            mie_q <= csr_if.csr_wr_data_in & IRQ_MASK;
    end

    // CSR read mux; writes to mip fall through here and are simply dropped.
    always_comb begin
        csr_if.csr_rd_data_out = '0;
        case (csr_if.csr_addr_in)
            CSR_MIE_ADDR: csr_if.csr_rd_data_out = mie_q;
            CSR_MIP_ADDR: csr_if.csr_rd_data_out = mip;
            default:      csr_if.csr_rd_data_out = '0;
        endcase
    end

    // Request and cause come straight from registered state, so reset and the
    // global enable take effect without waiting for a clock edge.
    always_comb begin
        pending       = mip & mie_q;
        winner        = irq_select(pending);
        irq_req_out   = mstatus_mie_in & (pending != '0);
        irq_cause_out = irq_req_out ? irq_cause(winner) : CAUSE_NONE;
    end

    assign mip_out = mip;
    assign mie_out = mie_q;

endmodule

// File: tb/tb_irq_modport.sv
// Bench for irq_modport with a two-stage synchroniser: a vector table applied
// through a scoreboard queue, then hand sequences for latency, same-cycle
// global enable and asynchronous reset during an active request.
module tb_irq_modport;

    localparam int S  = 2;
    localparam int EW = 32 + 32 + 32 + 1 + 4;

    logic clk;
    logic rst_n;
    logic eirq;
    logic tirq;
    logic sirq;
    logic mst_mie;
    logic [31:0] mip_out;
    logic [31:0] mie_out;
    logic        irq_req;
    logic [3:0]  irq_cause;

    irq_modport_if csr_bus ();

    irq_modport #(.SYNC_STAGES(S), .MIE_RST(32'h0)) dut (
        .ms_riscv32_mp_clk_in  (clk),
        .ms_riscv32_mp_rst_in  (rst_n),
        .ms_riscv32_mp_eirq_in (eirq),
        .ms_riscv32_mp_tirq_in (tirq),
        .ms_riscv32_mp_sirq_in (sirq),
        .mstatus_mie_in        (mst_mie),
        .csr_if                (csr_bus.slave),
        .mip_out               (mip_out),
        .mie_out               (mie_out),
        .irq_req_out           (irq_req),
        .irq_cause_out         (irq_cause)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic        e, t, s, mst, wr;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] x_mip, x_mie, x_rd;
        logic        x_req;
        logic [3:0]  x_cause;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic e, t, s, mst, wr,
                           input logic [11:0] waddr, input logic [31:0] wdata,
                           input logic [11:0] raddr,
                           input logic [31:0] x_mip, x_mie, x_rd,
                           input logic x_req, input logic [3:0] x_cause);
        vt[i].e = e; vt[i].t = t; vt[i].s = s; vt[i].mst = mst; vt[i].wr = wr;
        vt[i].waddr = waddr; vt[i].wdata = wdata; vt[i].raddr = raddr;
        vt[i].x_mip = x_mip; vt[i].x_mie = x_mie; vt[i].x_rd = x_rd;
        vt[i].x_req = x_req; vt[i].x_cause = x_cause;
    endtask

    // Driver: one CSR write strobe (optional) plus input levels, then let the
    // synchroniser settle and read back through the CSR bus.
    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        eirq = v.e; tirq = v.t; sirq = v.s; mst_mie = v.mst;
        csr_bus.csr_wr_en_in   = v.wr;
        csr_bus.csr_addr_in    = v.waddr;
        csr_bus.csr_wr_data_in = v.wdata;
        exp_q.push_back({v.x_mip, v.x_mie, v.x_rd, v.x_req, v.x_cause});
        @(posedge clk); #1;
        csr_bus.csr_wr_en_in = 1'b0;
        repeat (S - 1) @(posedge clk);
        @(negedge clk);
        csr_bus.csr_addr_in = v.raddr;
        #1;
    endtask

    // Scoreboard: pop the oldest expectation and compare every output.
    task automatic sb_check(input int idx);
        logic [EW-1:0] e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_mip"},   mip_out,                      e[100:69]);
        chk({tag, "_mie"},   mie_out,                      e[68:37]);
        chk({tag, "_rd"},    csr_bus.csr_rd_data_out,      e[36:5]);
        chk({tag, "_req"},   {31'd0, irq_req},             {31'd0, e[4]});
        chk({tag, "_cause"}, {28'd0, irq_cause},           {28'd0, e[3:0]});
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_bus.csr_wr_en_in = 1'b1; csr_bus.csr_addr_in = a; csr_bus.csr_wr_data_in = d;
        @(negedge clk);
        csr_bus.csr_wr_en_in = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; eirq = 0; tirq = 0; sirq = 0; mst_mie = 0;
        csr_bus.csr_wr_en_in = 0; csr_bus.csr_addr_in = 12'h0; csr_bus.csr_wr_data_in = 32'h0;

        //        e  t  s  mst wr waddr   wdata         raddr   mip        mie        rd         req cause
        set_vec(0,  0, 0, 0, 0, 0, 12'h000, 32'h0,        12'h304, 32'h000, 32'h000, 32'h000, 0, 4'd0);
        set_vec(1,  0, 1, 0, 1, 1, 12'h304, 32'h888,      12'h344, 32'h080, 32'h888, 32'h080, 1, 4'd7);
        set_vec(2,  1, 1, 1, 1, 0, 12'h000, 32'h0,        12'h304, 32'h888, 32'h888, 32'h888, 1, 4'd11);
        set_vec(3,  0, 1, 1, 1, 0, 12'h000, 32'h0,        12'h344, 32'h088, 32'h888, 32'h088, 1, 4'd3);
        set_vec(4,  0, 1, 0, 1, 0, 12'h000, 32'h0,        12'h344, 32'h080, 32'h888, 32'h080, 1, 4'd7);
        set_vec(5,  0, 0, 1, 0, 1, 12'h304, 32'h008,      12'h344, 32'h008, 32'h008, 32'h008, 0, 4'd0);
        set_vec(6,  0, 0, 1, 1, 0, 12'h000, 32'h0,        12'h304, 32'h008, 32'h008, 32'h008, 1, 4'd3);
        set_vec(7,  0, 0, 1, 1, 1, 12'h304, 32'hFFFF_FFFF, 12'h304, 32'h008, 32'h888, 32'h888, 1, 4'd3);
        set_vec(8,  0, 0, 1, 1, 1, 12'h344, 32'hFFFF_FFFF, 12'h344, 32'h008, 32'h888, 32'h008, 1, 4'd3);
        set_vec(9,  1, 0, 1, 1, 0, 12'h000, 32'h0,        12'h300, 32'h808, 32'h888, 32'h000, 1, 4'd11);
        set_vec(10, 1, 0, 1, 1, 1, 12'h304, 32'h0,        12'h123, 32'h808, 32'h000, 32'h000, 0, 4'd0);
        set_vec(11, 0, 1, 0, 1, 1, 12'h304, 32'h080,      12'h304, 32'h080, 32'h080, 32'h080, 1, 4'd7);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply_vec(vt[i]);
            sb_check(i);
        end

        // Latency: tirq raised at one negedge is visible only after S edges.
        eirq = 0; tirq = 0; sirq = 0; mst_mie = 1;
        csr_write(12'h304, 32'h888);
        repeat (S + 1) @(posedge clk);
        @(negedge clk);
        tirq = 1;
        @(posedge clk); #1;
        chk("lat_mip_early", mip_out, 32'h0);
        chk("lat_req_early", {31'd0, irq_req}, 32'd0);
        @(posedge clk); #1;
        chk("lat_mip", mip_out, 32'h80);
        chk("lat_req", {31'd0, irq_req}, 32'd1);
        chk("lat_cause", {28'd0, irq_cause}, 32'd7);

        // Global enable acts combinationally, leaving mip and mie untouched.
        @(negedge clk);
        tirq = 0; sirq = 1; mst_mie = 0;
        csr_write(12'h304, 32'h008);
        repeat (S + 1) @(posedge clk);
        @(negedge clk); #1;
        chk("mst_off_mip", mip_out, 32'h8);
        chk("mst_off_req", {31'd0, irq_req}, 32'd0);
        mst_mie = 1; #1;
        chk("mst_on_req", {31'd0, irq_req}, 32'd1);
        chk("mst_on_cause", {28'd0, irq_cause}, 32'd3);
        mst_mie = 0; #1;
        chk("mst_drop_req", {31'd0, irq_req}, 32'd0);
        chk("mst_drop_cause", {28'd0, irq_cause}, 32'd0);
        chk("mst_drop_mip", mip_out, 32'h8);
        chk("mst_drop_mie", mie_out, 32'h8);

        // Asynchronous reset in the middle of an active external request.
        @(negedge clk);
        sirq = 0; eirq = 1; mst_mie = 1;
        csr_write(12'h304, 32'h888);
        repeat (S + 1) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_pre_req", {31'd0, irq_req}, 32'd1);
        chk("rst_pre_cause", {28'd0, irq_cause}, 32'd11);
        #1 rst_n = 1'b0; #1;
        chk("rst_req", {31'd0, irq_req}, 32'd0);
        chk("rst_cause", {28'd0, irq_cause}, 32'd0);
        chk("rst_mip", mip_out, 32'h0);
        chk("rst_mie", mie_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_mip_early", mip_out, 32'h0);
        @(posedge clk); #1;
        chk("rel_mip", mip_out, 32'h800);
        chk("rel_req", {31'd0, irq_req}, 32'd0);
        chk("rel_cause", {28'd0, irq_cause}, 32'd0);

        chk("sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
